// File: rtl/gpu_rect_span_sequencer_pkg.sv
// Shared definitions for the rectangle span sequencer slice.
//   COORD_W : coordinate width (x, y, w, h, xpos, ypos)
//   RGB_W   : RGB888 colour width
//   LEN_W   : downstream span length code width
//   state_t : sequencer FSM states
//   len_code: forms the downstream length code from a clipped width
package gpu_rect_span_sequencer_pkg;

   localparam int unsigned COORD_W = 16;
   localparam int unsigned RGB_W   = 24;
   localparam int unsigned LEN_W   = 24;

   typedef enum logic [2:0] {
      IDLE,
      CLIP,
      DROP,
      REQ,
      RUN,
      GAP
   } state_t;

   // Zero-extend the clipped width, subtract the downstream adjustment, clamp at 0.
   function automatic logic [LEN_W-1:0] len_code(input logic [COORD_W-1:0] cw,
                                                 input logic [LEN_W-1:0]   adj);
      logic [LEN_W-1:0] ext;
      ext = LEN_W'(cw);
      return (ext > adj) ? (ext - adj) : '0;
   endfunction

endpackage

// File: rtl/gpu_rect_span_sequencer_if.sv
// Bus interfaces of the rectangle span sequencer.
//   gpu_cmd_if : rectangle-fill command channel (valid/ready)
//                master = command source, slave = sequencer
//   gpu_span_if: span request channel to the SDRAM write-control stage
//                master = sequencer, slave = write-control stage
interface gpu_cmd_if;
   import gpu_rect_span_sequencer_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [COORD_W-1:0] cmd_x;
   logic [COORD_W-1:0] cmd_y;
   logic [COORD_W-1:0] cmd_w;
   logic [COORD_W-1:0] cmd_h;
   logic [RGB_W-1:0]   cmd_color;

   modport master (output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
                   output cmd_ready);
endinterface

interface gpu_span_if;
   import gpu_rect_span_sequencer_pkg::*;

   logic [COORD_W-1:0] xpos;
   logic [COORD_W-1:0] ypos;
   logic [RGB_W-1:0]   pixel;
   logic [LEN_W-1:0]   len;
   logic               enable;
   logic               busy;

   modport master (output xpos, ypos, pixel, len, enable,
                   input  busy);
   modport slave  (input  xpos, ypos, pixel, len, enable,
                   output busy);
endinterface

// File: rtl/gpu_rect_span_sequencer_clip.sv
// gpu_rect_clip: registered rectangle clipper, captured on load.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture x/y/w/h this cycle
//   x, y, w, h : rectangle origin and size
//   cw         : clipped width  (min(x+w, H_DISP) - x)
//   y_end      : last row       (min(y+h, V_DISP) - 1)
//   empty      : rectangle lies off-screen or has zero size; cw/y_end are then meaningless
module gpu_rect_clip
   import gpu_rect_span_sequencer_pkg::*;
#(
   parameter int unsigned H_DISP = 800,
   parameter int unsigned V_DISP = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   output logic [COORD_W-1:0] cw,
   output logic [COORD_W-1:0] y_end,
   output logic               empty
);

   localparam int unsigned    CW1   = COORD_W + 1;
   localparam logic [CW1-1:0] H_LIM = CW1'(H_DISP);
   localparam logic [CW1-1:0] V_LIM = CW1'(V_DISP);

   // One extra bit so x+w and y+h never wrap.
   logic [CW1-1:0] x_sum, y_sum, x1, y1;
   logic           is_empty;

   always_comb begin
      x_sum    = {1'b0, x} + {1'b0, w};
      y_sum    = {1'b0, y} + {1'b0, h};
      x1       = (x_sum > H_LIM) ? H_LIM : x_sum;
      y1       = (y_sum > V_LIM) ? V_LIM : y_sum;
      is_empty = ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM) ||
                 (w == '0) || (h == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cw    <= '0;
         y_end <= '0;
         empty <= 1'b1;
      end else if (load) begin
         cw    <= COORD_W'(x1 - {1'b0, x});
         y_end <= COORD_W'(y1 - CW1'(1));
         empty <= is_empty;
      end
   end

endmodule

// File: rtl/gpu_rect_span_sequencer.sv
// gpu_rect_span_sequencer: accepts rectangle-fill commands, clips them to the
// display and issues one horizontal span per row to the SDRAM write-control stage.
//   clk, rst : clock, synchronous active-high reset
//   cmd      : command channel (valid/ready, x, y, w, h, colour)
//   span     : span channel (xpos, ypos, pixel, len, enable out; busy in)
//   seq_busy : high from command accept until the last span completes
//   done     : one-cycle pulse after the final span or a dropped empty command
module gpu_rect_span_sequencer
   import gpu_rect_span_sequencer_pkg::*;
#(
   parameter int unsigned H_DISP  = 800,
   parameter int unsigned V_DISP  = 480,
   parameter int unsigned GAP_CYC = 2,
   parameter int unsigned LEN_ADJ = 0
) (
   input  logic      clk,
   input  logic      rst,
   gpu_cmd_if.slave  cmd,
   gpu_span_if.master span,
   output logic      seq_busy,
   output logic      done
);

   // The downstream needs at least two idle cycles between spans.
   localparam int unsigned     GAP_EFF  = (GAP_CYC < 2) ? 2 : GAP_CYC;
   localparam int unsigned     GW       = $clog2(GAP_EFF);
   localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_EFF - 1);
   localparam logic [LEN_W-1:0] ADJ     = LEN_W'(LEN_ADJ);

   state_t             state;
   logic [GW-1:0]      gap_cnt;
   logic [COORD_W-1:0] lat_x;
   logic [COORD_W-1:0] lat_y;
   logic [RGB_W-1:0]   lat_color;
   logic               accept;

   logic [COORD_W-1:0] clip_cw;
   logic [COORD_W-1:0] clip_y_end;
   logic               clip_empty;

   always_comb begin
      accept = (state == IDLE) && cmd.cmd_ready && cmd.cmd_valid;
   end

   gpu_rect_clip #(
      .H_DISP (H_DISP),
      .V_DISP (V_DISP)
   ) u_clip (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .x     (cmd.cmd_x),
      .y     (cmd.cmd_y),
      .w     (cmd.cmd_w),
      .h     (cmd.cmd_h),
      .cw    (clip_cw),
      .y_end (clip_y_end),
      .empty (clip_empty)
   );

   // ypos doubles as the row counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         gap_cnt       <= '0;
         lat_x         <= '0;
         lat_y         <= '0;
         lat_color     <= '0;
         cmd.cmd_ready <= 1'b0;
         span.enable   <= 1'b0;
         span.xpos     <= '0;
         span.ypos     <= '0;
         span.pixel    <= '0;
         span.len      <= '0;
         seq_busy      <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // cmd_ready rises the cycle after done, so done and an accept never coincide.
               if (!cmd.cmd_ready) begin
                  cmd.cmd_ready <= 1'b1;
               end else if (cmd.cmd_valid) begin
                  cmd.cmd_ready <= 1'b0;
                  lat_x         <= cmd.cmd_x;
                  lat_y         <= cmd.cmd_y;
                  lat_color     <= cmd.cmd_color;
                  seq_busy      <= 1'b1;
                  state         <= CLIP;
               end
            end
            CLIP: begin
               if (clip_empty) begin
                  done     <= 1'b1;
                  seq_busy <= 1'b0;
                  state    <= DROP;
               end else begin
                  span.ypos   <= lat_y;
                  span.xpos   <= lat_x;
                  span.pixel  <= lat_color;
                  span.len    <= len_code(clip_cw, ADJ);
                  span.enable <= 1'b1;
                  state       <= REQ;
               end
            end
            DROP: begin
               cmd.cmd_ready <= 1'b1;
               state         <= IDLE;
            end
            REQ: begin
               if (span.busy) begin
                  span.enable <= 1'b0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (!span.busy) begin
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (span.ypos == clip_y_end) begin
                     done     <= 1'b1;
                     seq_busy <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     span.ypos   <= span.ypos + 1'b1;
                     span.enable <= 1'b1;
                     state       <= REQ;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
